// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the two-requester ALU arbiter
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef enum logic [OP_W-1:0] {
        ADD,
        SUB,
        SHR,
        SHL,
        AND,
        OR,
        RSV6,
        RSV7
    } alu_op_t;

    // Opcodes 6 and 7 carry no operation; the response flags them as errors.
    function automatic logic is_rsv(input logic [OP_W-1:0] op);
        return (alu_op_t'(op) == RSV6) || (alu_op_t'(op) == RSV7);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 8-bit combinational ALU
//
// Ports:
//   a_i, b_i : operands
//   op_i     : opcode (alu_op_t encoding)
//   y_o      : result, truncated to DATA_W bits; reserved opcodes give 0
module alu
    import alu_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (alu_op_t'(op_i))
            ADD:     y_o = a_i + b_i;
            SUB:     y_o = a_i - b_i;
            SHR:     y_o = a_i >> 1;
            SHL:     y_o = a_i << 1;
            AND:     y_o = a_i & b_i;
            OR:      y_o = a_i | b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - arbitrates two requesters onto one shared ALU
//
// Build option: ALU_ARB_RR_EN selects round-robin arbitration; when undefined,
// requester 0 has fixed priority.
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   reqN_valid/a/b/op/ready     : request handshake for requester N (N = 0, 1)
//   rsp0_valid, rsp1_valid      : one-cycle result strobe to the owning requester
//   rsp_q, rsp_err              : shared result and reserved-opcode flag
//   busy                        : an operation is in flight
//   ops_count                   : number of responses issued (wraps)
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_q,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_count
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [OP_W-1:0]     op_q;
    logic                id_q;
    logic [DATA_W-1:0]   result_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   alu_y;
    logic                grant0, grant1;
    logic                hs;

`ifdef ALU_ARB_RR_EN
    // prio_q = 1 means requester 1 wins the next tie.
    logic prio_q, prio_d;

    assign grant0 = req0_valid & (~req1_valid | ~prio_q);
    assign grant1 = req1_valid & (~req0_valid |  prio_q);

    always_comb begin
        prio_d = prio_q;
        if (hs) begin
            prio_d = ~req1_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & ~req0_valid;
`endif

    assign hs = req0_ready | req1_ready;

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so no ready is seen while reset is held.
                if (rst_n) begin
                    req0_ready = grant0;
                    req1_ready = grant1;
                    if (grant0 | grant1) begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp0_valid = ~id_q;
                rsp1_valid =  id_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (hs) begin
                id_q <= req1_ready;
                a_q  <= req1_ready ? req1_a  : req0_a;
                b_q  <= req1_ready ? req1_b  : req0_b;
                op_q <= req1_ready ? req1_op : req0_op;
            end
            // Result and error flag only move at the end of EXEC, so they
            // hold their previous values everywhere outside RESP.
            if (state_q == EXEC) begin
                result_q <= alu_y;
                err_q    <= is_rsv(op_q);
            end
            if (state_q == RESP) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    alu u_alu (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .y_o  (alu_y)
    );

    assign rsp_q     = result_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);
    assign ops_count = cnt_q;

endmodule
